// File: rtl/scan_chain_ctrl_if.sv
// Request/response handshake bundle for the scan chain controller.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_init;
    logic [CHAIN_LEN-1:0] req_pat;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;

    modport master (
        output req_valid, req_init, req_pat, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_init, req_pat, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Serial load/unload and async preset control for an external scan chain.
// Optional capture cycle after shifting: define SCAN_CTRL_CAPTURE_EN.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    scan_chain_ctrl_if.slave bus,
    output logic             scan_se,
    output logic             scan_si,
    output logic             scan_sdn,
    input  logic             scan_so,
    output logic             busy
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRESET  = 3'd1;
    localparam logic [2:0] SHIFT   = 3'd2;
`ifdef SCAN_CTRL_CAPTURE_EN
    localparam logic [2:0] CAPTURE = 3'd3;
`endif
    localparam logic [2:0] RESP    = 3'd4;

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [CHAIN_LEN-1:0] pat;
    logic [CHAIN_LEN-1:0] data;
    logic                 rvld;

    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.rsp_valid = rvld;
    assign bus.rsp_data  = data;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            scan_se  <= 1'b0;
            scan_si  <= 1'b0;
            scan_sdn <= 1'b1;
            rvld     <= 1'b0;
            data     <= '0;
            cnt      <= '0;
            pat      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (bus.req_init) begin
                            state    <= PRESET;
                            scan_sdn <= 1'b0;
                        end else begin
                            state   <= SHIFT;
                            scan_se <= 1'b1;
                            scan_si <= bus.req_pat[0];
                            cnt     <= '0;
                            // pat[0] always holds the next bit to drive
                            pat     <= bus.req_pat >> 1;
                        end
                    end
                end
                PRESET: begin
                    scan_sdn <= 1'b1;
                    state    <= IDLE;
                end
                SHIFT: begin
                    for (int i = 0; i < CHAIN_LEN; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            data[i] <= scan_so;
                        end
                    end
                    scan_si <= pat[0];
                    pat     <= pat >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(CHAIN_LEN - 1)) begin
                        scan_se <= 1'b0;
                        scan_si <= 1'b0;
`ifdef SCAN_CTRL_CAPTURE_EN
                        state   <= CAPTURE;
`else
                        state   <= RESP;
                        rvld    <= 1'b1;
`endif
                    end
                end
`ifdef SCAN_CTRL_CAPTURE_EN
                CAPTURE: begin
                    state <= RESP;
                    rvld  <= 1'b1;
                end
`endif
                RESP: begin
                    if (bus.rsp_ready) begin
                        rvld  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 16-flop chain model.
// Expectations follow SCAN_CTRL_CAPTURE_EN when defined.
module tb_scan_chain_ctrl;
    localparam int N = 16;

    logic         clk;
    logic         rstn;
    logic         se, si, sdn, so, busy;
    logic [N-1:0] ch;
    int           total;
    int           bad;

`ifdef SCAN_CTRL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif
    localparam logic [N-1:0] DIN = 16'h1234;

    scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus ();

    scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(8)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus),
        .scan_se         (se),
        .scan_si         (si),
        .scan_sdn        (sdn),
        .scan_so         (so),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ch[0] is the head flop, ch[N-1] the tail
    assign so = ch[N-1];
    always @(posedge clk or negedge sdn) begin
        if (!sdn) begin
            ch <= '1;
        end else if (se) begin
            ch <= {ch[N-2:0], si};
        end else if (CAP && busy) begin
            for (int k = 0; k < N; k++) ch[N-1-k] <= DIN[k];
        end
    end

    task automatic run_shift(input logic [N-1:0] p,
                             output logic [N-1:0] d,
                             output int lat, output int secnt,
                             output bit tmo);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_init  = 1'b0;
        bus.req_pat   = p;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat   = 0;
        secnt = se ? 1 : 0;
        tmo   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (se) secnt++;
            if (bus.rsp_valid) begin
                tmo = 1'b0;
                break;
            end
        end
        d = bus.rsp_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_init  = 1'b0;
        bus.req_pat   = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (sdn !== 1'b1) begin bad++; $display("FAIL rst_sdn got=%b want=1", sdn); end
        total++; if (se !== 1'b0) begin bad++; $display("FAIL rst_se got=%b want=0", se); end
        total++; if (si !== 1'b0) begin bad++; $display("FAIL rst_si got=%b want=0", si); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rvld got=%b want=0", bus.rsp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b want=1", bus.req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_preset;
        int lows, rv, lat, sc;
        bit tmo;
        logic [N-1:0] d;
        lows = 0;
        rv   = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_init  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_busy got=%b want=1", busy); end
        for (int c = 0; c < 5; c++) begin
            if (sdn === 1'b0) lows++;
            if (bus.rsp_valid !== 1'b0) rv++;
            @(posedge clk);
            #1;
        end
        total++; if (lows != 1) begin bad++; $display("FAIL pre_sdn_low got=%0d want=1", lows); end
        total++; if (rv != 0) begin bad++; $display("FAIL pre_rvld got=%0d want=0", rv); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL pre_idle got=%b want=1", bus.req_ready); end
        run_shift(16'h0000, d, lat, sc, tmo);
        total++; if (tmo) begin bad++; $display("FAIL pre_shift_timeout got=1 want=0"); end
        total++; if (d !== 16'hFFFF) begin bad++; $display("FAIL pre_unload got=%h want=ffff", d); end
    endtask

    task automatic test_load_unload;
        int lat, sc, elat;
        bit tmo;
        logic [N-1:0] d, exp;
        elat = CAP ? N + 1 : N;
        run_shift(16'hA5C3, d, lat, sc, tmo);
        total++; if (tmo) begin bad++; $display("FAIL lu_timeout got=1 want=0"); end
        total++; if (lat != elat) begin bad++; $display("FAIL lu_latency got=%0d want=%0d", lat, elat); end
        total++; if (sc != N) begin bad++; $display("FAIL lu_se_cycles got=%0d want=%0d", sc, N); end
        total++; if (lat - sc != (CAP ? 1 : 0)) begin bad++; $display("FAIL lu_gap got=%0d want=%0d", lat - sc, CAP ? 1 : 0); end
        total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL lu_idle got=%b%b want=01", bus.rsp_valid, bus.req_ready);
        end
        run_shift(16'h0000, d, lat, sc, tmo);
        exp = CAP ? DIN : 16'hA5C3;
        total++; if (d !== exp) begin bad++; $display("FAIL lu_unload got=%h want=%h", d, exp); end
    endtask

    task automatic test_capture;
        int lat, sc;
        bit tmo;
        logic [N-1:0] d, exp;
        run_shift(16'hFFFF, d, lat, sc, tmo);
        run_shift(16'h0000, d, lat, sc, tmo);
        exp = CAP ? DIN : 16'hFFFF;
        total++; if (d !== exp) begin bad++; $display("FAIL cap_unload got=%h want=%h", d, exp); end
    endtask

    task automatic test_backpressure;
        logic [N-1:0] d0, exp;
        bit tmo;
        int errs;
        exp = CAP ? DIN : 16'h0000;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_init  = 1'b0;
        bus.req_pat   = 16'h3C96;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        tmo = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                tmo = 1'b0;
                break;
            end
        end
        d0 = bus.rsp_data;
        total++; if (tmo) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
        total++; if (d0 !== exp) begin bad++; $display("FAIL bp_data got=%h want=%h", d0, exp); end
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.req_valid = c[0];
            bus.req_init  = 1'b1;
            @(posedge clk);
            #1;
            if (bus.rsp_data !== exp || bus.rsp_valid !== 1'b1 ||
                bus.req_ready !== 1'b0 || sdn !== 1'b1) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", errs); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_init  = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", bus.rsp_valid); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_reset_mid;
        int rv;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_init  = 1'b0;
        bus.req_pat   = 16'hFFFF;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        total++; if (se !== 1'b0 || si !== 1'b0 || sdn !== 1'b1) begin
            bad++; $display("FAIL mid_scan got=%b%b%b want=001", se, si, sdn);
        end
        total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0000) begin
            bad++; $display("FAIL mid_rsp got=%b/%h want=0/0000", bus.rsp_valid, bus.rsp_data);
        end
        total++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_state got=%b%b want=10", bus.req_ready, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        rv = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) rv++;
        end
        total++; if (rv != 0) begin bad++; $display("FAIL mid_no_rsp got=%0d want=0", rv); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_preset;
        test_load_unload;
        test_capture;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
